snes_video_source: RTL and testbench

- Transmitter end of the SNES-to-HDMI video/refresh interface.
- Generates SNES-style dot timing (dotclk, hblank, vblank, xs, ys) and the DRAM-refresh window (snes_refresh), with per-dot rgb5 fetched from a pixel source.
- Freezes atomically on pause_snes_for_frame_sync from the HDMI converter.
- Used as the PPU-side front end and as a standalone stimulus source for converter bring-up.

---
 rtl/snes_video_pkg.sv | 24 ++
 rtl/snes_video_source_dot_counter.sv | 50 +++++
 rtl/snes_video_source.sv | 109 ++++++++++
 tb/tb_snes_video_source.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_video_pkg.sv
// Shared timing defaults, counter widths and small helpers for the SNES video source.
package snes_video_pkg;

    localparam int DEF_CLKS_PER_DOT    = 4;
    localparam int DEF_DOTS_PER_LINE   = 341;
    localparam int DEF_LINES_PER_FRAME = 262;
    localparam int DEF_ACTIVE_W        = 256;
    localparam int DEF_ACTIVE_H        = 224;
    localparam int DEF_REFRESH_START   = 536;
    localparam int DEF_REFRESH_LEN     = 40;

    // Sized for up to 512 dots/lines and 2048 master clocks per line.
    localparam int H_W  = 9;
    localparam int V_W  = 9;
    localparam int LC_W = 11;

    typedef logic [14:0] rgb555_t;

    // Lines past 255 report FF so the converter never sees a second "line 2".
    function automatic logic [7:0] line8_sat(input logic [V_W-1:0] v);
        return (v < V_W'(256)) ? v[7:0] : 8'hFF;
    endfunction

endpackage

// File: rtl/snes_video_source_dot_counter.sv
// Master-clock / dot / line / field counters for the SNES video source; everything holds while en is low.
module snes_dot_counter
    import snes_video_pkg::*;
#(
    parameter int CPD  = DEF_CLKS_PER_DOT,
    parameter int DPL  = DEF_DOTS_PER_LINE,
    parameter int LPF  = DEF_LINES_PER_FRAME,
    parameter int MC_W = $clog2(DEF_CLKS_PER_DOT)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    output logic [MC_W-1:0] mc,
    output logic [H_W-1:0]  h,
    output logic [V_W-1:0]  v,
    output logic [LC_W-1:0] lc,
    output logic            field
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mc    <= '0;
            h     <= '0;
            v     <= '0;
            lc    <= '0;
            field <= 1'b0;
        end else if (en) begin
            if (mc == MC_W'(CPD - 1)) begin
                mc <= '0;
                if (h == H_W'(DPL - 1)) begin
                    h  <= '0;
                    lc <= '0;
                    if (v == V_W'(LPF - 1)) begin
                        v     <= '0;
                        field <= ~field;
                    end else begin
                        v <= v + V_W'(1);
                    end
                end else begin
                    h  <= h + H_W'(1);
                    lc <= lc + LC_W'(1);
                end
            end else begin
                mc <= mc + MC_W'(1);
                lc <= lc + LC_W'(1);
            end
        end
    end

endmodule

// File: rtl/snes_video_source.sv
// SNES-style dot/line timing, refresh window and pixel fetch, freezable by the converter.
// Define SNES_VIDEO_SOURCE_TESTPAT_EN to replace pix_rgb with an internal 8-bar pattern.
module snes_video_source
    import snes_video_pkg::*;
#(
    parameter int CLKS_PER_DOT    = DEF_CLKS_PER_DOT,
    parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int ACTIVE_W        = DEF_ACTIVE_W,
    parameter int ACTIVE_H        = DEF_ACTIVE_H,
    parameter int REFRESH_START   = DEF_REFRESH_START,
    parameter int REFRESH_LEN     = DEF_REFRESH_LEN
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pause,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    input  rgb555_t     pix_rgb,
    output logic        dotclk,
    output logic        hblank,
    output logic        vblank,
    output rgb555_t     rgb5,
    output logic [8:0]  xs,
    output logic [8:0]  ys,
    output logic        snes_refresh,
    output logic        frame_start
);

    localparam int MC_W = $clog2(CLKS_PER_DOT);

    logic [MC_W-1:0] mc;
    logic [H_W-1:0]  h;
    logic [V_W-1:0]  v;
    logic [LC_W-1:0] lc;
    logic            field;
    logic [7:0]      xs_h;
    logic [7:0]      line8;
    logic            ys_field;
    rgb555_t         src_rgb;
    logic            active;

    // pause is level-sampled every clk: high freezes counters and outputs as they are,
    // low lets the very next edge continue from the frozen state.
    snes_dot_counter #(
        .CPD  (CLKS_PER_DOT),
        .DPL  (DOTS_PER_LINE),
        .LPF  (LINES_PER_FRAME),
        .MC_W (MC_W)
    ) u_counter (
        .clk    (clk),
        .resetn (resetn),
        .en     (~pause),
        .mc     (mc),
        .h      (h),
        .v      (v),
        .lc     (lc),
        .field  (field)
    );

    assign active = (h < H_W'(ACTIVE_W)) && (v < V_W'(ACTIVE_H));

`ifdef SNES_VIDEO_SOURCE_TESTPAT_EN
    assign src_rgb = {{5{h[7]}}, {5{h[6]}}, {5{h[5]}}};
`else
    assign src_rgb = pix_rgb;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_x        <= '0;
            pix_y        <= '0;
            dotclk       <= 1'b0;
            hblank       <= 1'b1;
            vblank       <= 1'b1;
            rgb5         <= '0;
            xs_h         <= '0;
            line8        <= '0;
            ys_field     <= 1'b0;
            snes_refresh <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (!pause) begin
                dotclk       <= (mc >= MC_W'(CLKS_PER_DOT / 2));
                snes_refresh <= (lc >= LC_W'(REFRESH_START)) &&
                                (lc <  LC_W'(REFRESH_START + REFRESH_LEN));
                frame_start  <= (v == '0) && (h == '0) && (mc == MC_W'(1));
                if (mc == '0) begin
                    pix_x <= h[7:0];
                    pix_y <= v[7:0];
                end
                // The pixel requested at mc==0 comes back one clk later.
                if (mc == MC_W'(1)) begin
                    rgb5     <= active ? src_rgb : '0;
                    hblank   <= (h >= H_W'(ACTIVE_W));
                    vblank   <= (v >= V_W'(ACTIVE_H));
                    xs_h     <= h[7:0];
                    line8    <= line8_sat(v);
                    ys_field <= field;
                end
            end
        end
    end

    assign xs = {xs_h, dotclk};
    assign ys = {ys_field, line8};

endmodule

// File: tb/tb_snes_video_source.sv
// Directed bench: default-timing instance for dot/line/pause/reset checks, short-line instance for frame checks.
module tb_snes_video_source;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        d_pause = 1'b0;
    logic        s_pause = 1'b0;
    logic        pix_mode = 1'b0;

    logic [7:0]  d_pix_x, d_pix_y, s_pix_x, s_pix_y;
    logic [14:0] d_pix_rgb, s_pix_rgb, d_rgb5, s_rgb5;
    logic        d_dotclk, d_hblank, d_vblank, d_snes_refresh, d_frame_start;
    logic        s_dotclk, s_hblank, s_vblank, s_snes_refresh, s_frame_start;
    logic [8:0]  d_xs, d_ys, s_xs, s_ys;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;

    // monitor / scoreboard state for the short-line instance
    logic        mon_on = 1'b0;
    logic [8:0]  exp_q[$];
    int          mon_clk = 0, last_fs = 0, n_frames = 0, ref_cnt = 0, ref_run = 0, blank_viol = 0;
    logic        exp_field = 1'b0, prev_hb = 1'b1, prev_ref = 1'b0;

    assign d_pix_rgb = pix_mode ? {d_pix_y[6:0], d_pix_x} : 15'h7FFF;
    assign s_pix_rgb = 15'h7FFF;

    always #5 clk = ~clk;

    snes_video_source u_dut (
        .clk(clk), .resetn(resetn), .pause(d_pause),
        .pix_x(d_pix_x), .pix_y(d_pix_y), .pix_rgb(d_pix_rgb),
        .dotclk(d_dotclk), .hblank(d_hblank), .vblank(d_vblank), .rgb5(d_rgb5),
        .xs(d_xs), .ys(d_ys), .snes_refresh(d_snes_refresh), .frame_start(d_frame_start)
    );

    snes_video_source #(
        .CLKS_PER_DOT(4), .DOTS_PER_LINE(20), .LINES_PER_FRAME(262),
        .ACTIVE_W(16), .ACTIVE_H(224), .REFRESH_START(40), .REFRESH_LEN(12)
    ) u_dut_s (
        .clk(clk), .resetn(resetn), .pause(s_pause),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_rgb(s_pix_rgb),
        .dotclk(s_dotclk), .hblank(s_hblank), .vblank(s_vblank), .rgb5(s_rgb5),
        .xs(s_xs), .ys(s_ys), .snes_refresh(s_snes_refresh), .frame_start(s_frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    task automatic run_to(input int n);
        while (t < n) step(1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pix_x"},   32'(d_pix_x), 32'h0);
        check({tag, "_pix_y"},   32'(d_pix_y), 32'h0);
        check({tag, "_dotclk"},  32'(d_dotclk), 32'h0);
        check({tag, "_hblank"},  32'(d_hblank), 32'h1);
        check({tag, "_vblank"},  32'(d_vblank), 32'h1);
        check({tag, "_rgb5"},    32'(d_rgb5), 32'h0);
        check({tag, "_xs"},      32'(d_xs), 32'h0);
        check({tag, "_ys"},      32'(d_ys), 32'h0);
        check({tag, "_refresh"}, 32'(d_snes_refresh), 32'h0);
        check({tag, "_fstart"},  32'(d_frame_start), 32'h0);
    endtask

    // Scoreboard for the short-line instance (80 clks/line, 262 lines, 20960 clks/frame).
    always @(negedge clk) begin
        if (mon_on) begin
            logic [8:0] v_exp;
            mon_clk++;
            if (s_frame_start) begin
                if (n_frames > 0) begin
                    check("frame_period", 32'(mon_clk - last_fs), 32'd20960);
                    check("refresh_per_frame", 32'(ref_cnt), 32'd262);
                end
                check("field", 32'(s_ys[8]), 32'(exp_field));
                exp_field = ~exp_field;
                last_fs   = mon_clk;
                ref_cnt   = 0;
                n_frames++;
            end
            if (s_snes_refresh && !prev_ref) begin
                ref_cnt++;
                ref_run = 0;
            end
            if (s_snes_refresh) ref_run++;
            if (!s_snes_refresh && prev_ref) check("refresh_width", 32'(ref_run), 32'd12);
            if (!s_hblank && prev_hb) begin
                if (exp_q.size() == 0) begin
                    check("line_queue_empty", 32'd0, 32'd1);
                end else begin
                    v_exp = exp_q.pop_front();
                    check("line8", 32'(s_ys[7:0]), (v_exp < 9'd256) ? 32'(v_exp[7:0]) : 32'hFF);
                    check("vblank_line", 32'(s_vblank), (v_exp >= 9'd224) ? 32'd1 : 32'd0);
                end
            end
            if (s_hblank || s_vblank) begin
                if (s_rgb5 != 15'h0) blank_viol++;
            end
`ifndef SNES_VIDEO_SOURCE_TESTPAT_EN
            else if (s_rgb5 != 15'h7FFF) blank_viol++;
`endif
            prev_hb  = s_hblank;
            prev_ref = s_snes_refresh;
        end
    end

    initial begin
        int bad;
        int cnt;

        // Two full short frames plus line 0 of the third.
        for (int f = 0; f < 2; f++)
            for (int v = 0; v < 262; v++) exp_q.push_back(9'(v));
        exp_q.push_back(9'd0);

        #1 resetn = 1'b0;
        #2 check_reset("rst0");
        mon_on = 1'b1;
        step(2);
        resetn = 1'b1;
        for (int i = 0; i < 45000 && n_frames < 3; i++) step(1);
        #1;
        check("frame_run_done", 32'(n_frames), 32'd3);
        check("line_queue_drained", 32'(exp_q.size()), 32'd0);
        check("blank_gating", 32'(blank_viol), 32'd0);
        mon_on = 1'b0;

        // Line-level timing on the default instance.
        step(1);
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        t = 0;
        run_to(1);
        check("clk0_hblank", 32'(d_hblank), 32'h1);
        check("clk0_dotclk", 32'(d_dotclk), 32'h0);
        run_to(2);
        check("clk1_hblank", 32'(d_hblank), 32'h0);
        check("clk1_vblank", 32'(d_vblank), 32'h0);
        check("clk1_rgb5", 32'(d_rgb5), 32'h7FFF);
        check("clk1_fstart", 32'(d_frame_start), 32'h1);
        check("clk1_ys", 32'(d_ys), 32'h000);
        run_to(3);
        check("clk2_dotclk", 32'(d_dotclk), 32'h1);
        check("clk2_xs", 32'(d_xs), 32'h001);
        check("clk2_fstart", 32'(d_frame_start), 32'h0);
        run_to(5);
        check("clk4_dotclk", 32'(d_dotclk), 32'h0);
        run_to(6);
        check("dot1_xs", 32'(d_xs), 32'h002);
        check("dot1_pix_x", 32'(d_pix_x), 32'h01);
        run_to(536);
        check("refresh_pre", 32'(d_snes_refresh), 32'h0);
        run_to(537);
        check("refresh_first", 32'(d_snes_refresh), 32'h1);
        run_to(576);
        check("refresh_last", 32'(d_snes_refresh), 32'h1);
        run_to(577);
        check("refresh_post", 32'(d_snes_refresh), 32'h0);
        run_to(1025);
        check("dot255_hblank", 32'(d_hblank), 32'h0);
        check("dot255_rgb5", 32'(d_rgb5), 32'h7FFF);
        run_to(1026);
        check("dot256_hblank", 32'(d_hblank), 32'h1);
        check("dot256_rgb5", 32'(d_rgb5), 32'h0);
        run_to(1365);
        check("line1_pix_y", 32'(d_pix_y), 32'h01);
        run_to(1366);
        check("line1_ys", 32'(d_ys), 32'h001);

        // Pause 10 clks into the line-2 refresh window (line 2 starts at clk 2728).
        run_to(3274);
        check("pre_pause_ys", 32'(d_ys), 32'h002);
        check("pre_pause_refresh", 32'(d_snes_refresh), 32'h1);
        d_pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            step(1);
            if (!(d_xs == 9'h110 && d_ys == 9'h002 && d_snes_refresh && !d_frame_start &&
                  d_rgb5 == 15'h7FFF && !d_hblank && !d_vblank && !d_dotclk &&
                  d_pix_x == 8'h88 && d_pix_y == 8'h02)) bad++;
        end
        check("pause_hold_bad_cycles", 32'(bad), 32'd0);
        check("pause_refresh", 32'(d_snes_refresh), 32'h1);
        d_pause = 1'b0;
        step(1);
        check("resume_xs", 32'(d_xs), 32'h111);
        check("resume_dotclk", 32'(d_dotclk), 32'h1);
        cnt = 0;
        while (d_snes_refresh && cnt < 100) begin
            cnt++;
            step(1);
        end
        check("resume_refresh_remaining", 32'(cnt), 32'd30);

        // Reset mid-line while paused.
        step(20);
        d_pause = 1'b1;
        step(3);
        #2 resetn = 1'b0;
        #1 check_reset("rst_paused");
        d_pause = 1'b0;
        step(1);
        resetn = 1'b1;
        pix_mode = 1'b1;
        t = 0;
        run_to(1);
        check("restart_pix_x", 32'(d_pix_x), 32'h00);
        run_to(2);
        check("restart_fstart", 32'(d_frame_start), 32'h1);
        check("restart_xs", 32'(d_xs), 32'h000);
        check("restart_ys", 32'(d_ys), 32'h000);
        check("restart_hblank", 32'(d_hblank), 32'h0);
        run_to(130);
`ifdef SNES_VIDEO_SOURCE_TESTPAT_EN
        check("dot32_rgb5", 32'(d_rgb5), 32'h001F);
`else
        check("dot32_rgb5", 32'(d_rgb5), 32'h0020);
`endif
        run_to(1022);
`ifdef SNES_VIDEO_SOURCE_TESTPAT_EN
        check("dot255_pat", 32'(d_rgb5), 32'h7FFF);
`else
        check("dot255_fetch", 32'(d_rgb5), 32'h00FF);
`endif
        run_to(1766);
`ifdef SNES_VIDEO_SOURCE_TESTPAT_EN
        check("line1_dot100", 32'(d_rgb5), 32'h03FF);
`else
        check("line1_dot100", 32'(d_rgb5), 32'h0164);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
